reg_file_mt_bank: RTL
=====================

REG_FILE_MT_BANK -- requirements
Module: reg_file_mt_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, register width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register index width; each thread has 2^ADDR_WIDTH registers.
REQ-003 SHALL have parameter TH_ID_WIDTH, default 2, thread id width; there are 2^TH_ID_WIDTH threads.
REQ-004 SHALL have parameter NUM_RD, default 2, number of read ports, minimum 1.
REQ-005 SHALL have ports as follows, in this order:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- w0_en, w0_th, w0_addr, w0_data  in  1/TH_ID_WIDTH/ADDR_WIDTH/DATA_WIDTH  write port 0 (ALU writeback).
- w1_en, w1_th, w1_addr, w1_data  in  same widths  write port 1 (load return).
- rd_th  in  TH_ID_WIDTH  thread shared by all read ports.
- rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port k in bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  NUM_RD*DATA_WIDTH  packed read data, same packing.
- rd_pending  out  NUM_RD  per-port scoreboard pending flag.
- sb_set_en, sb_set_th, sb_set_addr  in  1/TH_ID_WIDTH/ADDR_WIDTH  mark a register pending.
- clr_req, clr_th  in  1/TH_ID_WIDTH  request a thread flush.
- clr_busy  out  1  flush sweep in progress.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Function
REQ-006 Register 0 of every thread SHALL read as zero; writes to it SHALL be discarded.
REQ-007 Reads SHALL be combinational; priority: addr==0 -> 0, then clr_th flush zeroing (REQ-014), then w1 forward, then w0 forward, then array.
REQ-008 A forward SHALL occur only when port enabled, addr!=0, port thread==rd_th and port addr==read addr.
REQ-009 Writes SHALL take effect at the clock edge; the value is visible via the array from the next cycle.
REQ-010 w0 and w1 targeting the same thread/addr in one cycle: w1_data SHALL be stored; differing targets both SHALL be stored.
REQ-011 Clear FSM states: IDLE, SWEEP, DONE.
REQ-012 IDLE: clr_req=1 SHALL latch clr_th, load sweep index 1, enter SWEEP; clr_busy=1 from the next cycle.
REQ-013 SWEEP: each cycle SHALL zero register [clr_th][index] and increment; at index 2^ADDR_WIDTH-1 SHALL go to DONE; sweep duration exactly 2^ADDR_WIDTH-1 cycles.
REQ-014 While clr_busy, reads with rd_th==latched thread SHALL return 0, and w0/w1 writes to that thread SHALL be dropped; other threads SHALL be unaffected.
REQ-015 DONE: clr_done=1, clr_busy=0 for one cycle, then IDLE; clr_req in SWEEP or DONE SHALL be ignored (not queued).
REQ-016 Index counter SHALL be ADDR_WIDTH bits and SHALL not wrap into register 0.

Reset
REQ-017 reset=1 SHALL, at the edge, zero every register of every thread, clear all pending bits, set FSM to IDLE, clr_busy=0, clr_done=0.
REQ-018 reset during SWEEP SHALL abort the sweep with no clr_done pulse; reset SHALL override all writes, sb_set and clr_req in that cycle.

Configuration
REQ-019 Macro REG_FILE_SCOREBOARD_EN SHALL compile in a per-thread, per-register pending bit array.
REQ-020 With it: sb_set_en sets pending[th][addr] (addr!=0); any accepted write to that register clears it; set and clear same cycle -> set wins; flush clears all of the thread's bits; rd_pending[k] = stored bit AND NOT a same-cycle accepted write to that register; R0 never pending.
REQ-021 Without it: ports remain present, sb_set_* ignored, rd_pending tied to 0, no pending storage.

Structure
REQ-022 A shared package rf_pkg SHALL hold the clear FSM state encoding and default parameter constants.
REQ-023 The clear FSM plus sweep counter SHALL be a sub-module rf_clr_seq; array, forwarding and scoreboard stay in reg_file_mt_bank.

Verification
REQ-024 Reset, then read T0..T3 R1..R15 -> all rd_data 0, rd_pending 0, clr_busy 0.
REQ-025 w0 T1 R5=0xAA and read T1 R5 same cycle -> rd_data 0xAA; w0 T1 R5 plus w1 T1 R5=0xBB -> next cycle reads 0xBB.
REQ-026 Write T2 R0=0xFF -> read T2 R0 returns 0; w0 T3 R4=0x11 with rd_th=2 -> no forward, rd_data is the array value.
REQ-027 Fill T1 R1..R15, clr_req T1 -> clr_busy 15 cycles, clr_done one pulse, T1 all 0, T0/T2/T3 unchanged; mid-sweep write T1 dropped, write T0 stored.
REQ-028 Scoreboard build: sb_set T0 R7 -> rd_pending 1; w1 T0 R7 -> same-cycle rd_pending 0, stays 0; sb_set and write same cycle -> pending 1.
REQ-029 Reset asserted at sweep cycle 5 -> clr_busy 0 next cycle, no clr_done, all registers 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the multithreaded register file: default geometry and
// the encoding of the thread-flush sequencer states.
package rf_pkg;

  localparam int RF_DATA_WIDTH  = 64;
  localparam int RF_ADDR_WIDTH  = 4;
  localparam int RF_TH_ID_WIDTH = 2;
  localparam int RF_NUM_RD      = 2;

  typedef logic [1:0] clr_state_t;

  localparam logic [1:0] CLR_IDLE  = 2'd0;
  localparam logic [1:0] CLR_SWEEP = 2'd1;
  localparam logic [1:0] CLR_DONE  = 2'd2;

endpackage

// File: rtl/rf_clr_seq.sv
// Thread-flush sequencer: latches the thread to clear, then walks registers
// 1..2^ADDR_WIDTH-1 one per cycle before pulsing done.
module rf_clr_seq
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH  = RF_ADDR_WIDTH,
  parameter int TH_ID_WIDTH = RF_TH_ID_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr_req,
  input  logic [TH_ID_WIDTH-1:0] clr_th,
  output logic                   clr_busy,
  output logic                   clr_done,
  output logic                   sweep_en,
  output logic [TH_ID_WIDTH-1:0] sweep_th,
  output logic [ADDR_WIDTH-1:0]  sweep_idx
);

  clr_state_t             state_q, state_d;
  logic [TH_ID_WIDTH-1:0] th_q, th_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;

  // Index starts at 1 and stops at all-ones, so register 0 is never visited.
  always_comb begin
    state_d = state_q;
    th_d    = th_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_SWEEP;
          th_d    = clr_th;
          idx_d   = ADDR_WIDTH'(1);
        end
      end
      CLR_SWEEP: begin
        if (idx_q == '1) begin
          state_d = CLR_DONE;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_IDLE;
      th_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      th_q    <= th_d;
      idx_q   <= idx_d;
    end
  end

  assign clr_busy  = (state_q == CLR_SWEEP);
  assign clr_done  = (state_q == CLR_DONE);
  assign sweep_en  = clr_busy;
  assign sweep_th  = th_q;
  assign sweep_idx = idx_q;

endmodule

// File: rtl/reg_file_mt_bank.sv
// Multithreaded register bank: two write ports with read forwarding, a thread
// flush sweep, and an optional pending scoreboard (REG_FILE_SCOREBOARD_EN).
module reg_file_mt_bank
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH  = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = RF_ADDR_WIDTH,
  parameter int TH_ID_WIDTH = RF_TH_ID_WIDTH,
  parameter int NUM_RD      = RF_NUM_RD
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w0_en,
  input  logic [TH_ID_WIDTH-1:0]       w0_th,
  input  logic [ADDR_WIDTH-1:0]        w0_addr,
  input  logic [DATA_WIDTH-1:0]        w0_data,
  input  logic                         w1_en,
  input  logic [TH_ID_WIDTH-1:0]       w1_th,
  input  logic [ADDR_WIDTH-1:0]        w1_addr,
  input  logic [DATA_WIDTH-1:0]        w1_data,
  input  logic [TH_ID_WIDTH-1:0]       rd_th,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_pending,
  input  logic                         sb_set_en,
  input  logic [TH_ID_WIDTH-1:0]       sb_set_th,
  input  logic [ADDR_WIDTH-1:0]        sb_set_addr,
  input  logic                         clr_req,
  input  logic [TH_ID_WIDTH-1:0]       clr_th,
  output logic                         clr_busy,
  output logic                         clr_done
);

  localparam int NUM_ENT = 1 << (TH_ID_WIDTH + ADDR_WIDTH);
  localparam int NUM_REG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  mem_q [NUM_ENT];
  logic [DATA_WIDTH-1:0]  mem_d [NUM_ENT];
  logic [ADDR_WIDTH-1:0]  rd_a  [NUM_RD];
  logic                   sweep_en;
  logic [TH_ID_WIDTH-1:0] sweep_th;
  logic [ADDR_WIDTH-1:0]  sweep_idx;
  logic                   w0_acc, w1_acc, rd_flushed;

  rf_clr_seq #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .TH_ID_WIDTH (TH_ID_WIDTH)
  ) u_clr_seq (
    .clk       (clk),
    .reset     (reset),
    .clr_req   (clr_req),
    .clr_th    (clr_th),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .sweep_en  (sweep_en),
    .sweep_th  (sweep_th),
    .sweep_idx (sweep_idx)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_a
    assign rd_a[k] = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Writes into the thread being flushed are dropped; R0 is never stored.
  assign w0_acc     = w0_en && (w0_addr != '0) && !(clr_busy && (w0_th == sweep_th));
  assign w1_acc     = w1_en && (w1_addr != '0) && !(clr_busy && (w1_th == sweep_th));
  assign rd_flushed = clr_busy && (rd_th == sweep_th);

  // w1 is applied after w0 so it wins a same-target collision.
  always_comb begin
    mem_d = mem_q;
    if (w0_acc)   mem_d[{w0_th, w0_addr}]     = w0_data;
    if (w1_acc)   mem_d[{w1_th, w1_addr}]     = w1_data;
    if (sweep_en) mem_d[{sweep_th, sweep_idx}] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENT; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_a[k] == '0 || rd_flushed) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (w1_en && (w1_th == rd_th) && (w1_addr == rd_a[k])) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w1_data;
      end else if (w0_en && (w0_th == rd_th) && (w0_addr == rd_a[k])) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w0_data;
      end else begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[{rd_th, rd_a[k]}];
      end
    end
  end

`ifdef REG_FILE_SCOREBOARD_EN
  logic [NUM_ENT-1:0] pend_q, pend_d;
  logic               sb_acc;

  assign sb_acc = sb_set_en && (sb_set_addr != '0) && !(clr_busy && (sb_set_th == sweep_th));

  // Set is applied last so it wins over a same-cycle write clear.
  always_comb begin
    pend_d = pend_q;
    if (w0_acc) pend_d[{w0_th, w0_addr}] = 1'b0;
    if (w1_acc) pend_d[{w1_th, w1_addr}] = 1'b0;
    if (clr_busy) begin
      for (int a = 0; a < NUM_REG; a++) pend_d[{sweep_th, ADDR_WIDTH'(a)}] = 1'b0;
    end
    if (sb_acc) pend_d[{sb_set_th, sb_set_addr}] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    rd_pending = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_pending[k] = pend_q[{rd_th, rd_a[k]}] && !rd_flushed
                      && !(w0_acc && (w0_th == rd_th) && (w0_addr == rd_a[k]))
                      && !(w1_acc && (w1_th == rd_th) && (w1_addr == rd_a[k]));
    end
  end
`else
  logic sb_unused;
  assign sb_unused  = ^{sb_set_en, sb_set_th, sb_set_addr};
  assign rd_pending = '0;
`endif

endmodule
